// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide unit: operand width, op encodings
// and sequencer state encoding.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_FIXUP = 2'b10;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring
// divide step on a double-width accumulator {upper, lower}.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] trial_s;
  logic [WIDTH:0] diff_s;

  // Divide keeps {remainder, dividend/quotient}; multiply keeps {partial, multiplier}
  always_comb begin
    sum_s    = '0;
    trial_s  = '0;
    diff_s   = '0;
    acc_next = '0;
    if (is_div) begin
      trial_s = acc[2*WIDTH-1:WIDTH-1];
      diff_s  = trial_s - {1'b0, operand};
      if (diff_s[WIDTH]) begin
        acc_next = {trial_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {diff_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      if (acc[0]) begin
        sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
      end else begin
        sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]};
      end
      acc_next = {sum_s, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; sequences the iterative
// datapath, applies sign fixup and stalls the pipeline while a result is pending.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITERS = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  input  logic             mfhi_req,
  input  logic             mflo_req,
  output logic [WIDTH-1:0] read_data,
  output logic             busy,
  output logic             stall
);

  localparam int CNT_W = $clog2(ITERS);

  logic [1:0]         state_r;
  logic               busy_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [WIDTH-1:0]   operand_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               is_div_r;
  logic               res_neg_r;
  logic               rem_neg_r;
  logic               div_zero_r;

  logic               is_signed_s;
  logic               is_div_s;
  logic               rs_neg_s;
  logic               rt_neg_s;
  logic [WIDTH-1:0]   rs_abs_s;
  logic [WIDTH-1:0]   rt_abs_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_r),
    .acc      (acc_r),
    .operand  (operand_r),
    .acc_next (acc_next_s)
  );

  // Operand decode at issue: magnitudes for signed ops, raw values otherwise
  always_comb begin
    is_signed_s = (op == MD_MULT) || (op == MD_DIV);
    is_div_s    = !((op == MD_MULT) || (op == MD_MULTU));
    rs_neg_s    = is_signed_s & rs[WIDTH-1];
    rt_neg_s    = is_signed_s & rt[WIDTH-1];
    rs_abs_s    = rs_neg_s ? -rs : rs;
    rt_abs_s    = rt_neg_s ? -rt : rt;
  end

  // Sign fixup; a zero divisor forces an all-ones quotient while the
  // remainder path naturally reproduces the dividend as issued
  always_comb begin
    prod_s = res_neg_r ? -acc_r : acc_r;
    rem_s  = rem_neg_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
    if (div_zero_r) begin
      quo_s = '1;
    end else begin
      quo_s = res_neg_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    end
  end

  // Sequencer FSM, iteration counter and HI/LO commit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      cnt_r      <= '0;
      acc_r      <= '0;
      operand_r  <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      is_div_r   <= 1'b0;
      res_neg_r  <= 1'b0;
      rem_neg_r  <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !flush) begin
            state_r    <= ST_RUN;
            busy_r     <= 1'b1;
            cnt_r      <= '0;
            is_div_r   <= is_div_s;
            res_neg_r  <= rs_neg_s ^ rt_neg_s;
            rem_neg_r  <= rs_neg_s;
            div_zero_r <= is_div_s && (rt == '0);
            operand_r  <= is_div_s ? rt_abs_s : rs_abs_s;
            acc_r      <= {{WIDTH{1'b0}}, (is_div_s ? rs_abs_s : rt_abs_s)};
          end
        end
        ST_RUN: begin
          if (flush) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_W'(ITERS - 1)) begin
              state_r <= ST_FIXUP;
            end
          end
        end
        ST_FIXUP: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          if (!flush) begin
            if (is_div_r) begin
              lo_r <= quo_s;
              hi_r <= rem_s;
            end else begin
              {hi_r, lo_r} <= prod_s;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // HI has priority when both registers are requested
  always_comb begin
    if (mfhi_req) begin
      read_data = hi_r;
    end else if (mflo_req) begin
      read_data = lo_r;
    end else begin
      read_data = '0;
    end
  end

  assign busy  = busy_r;
  assign stall = busy_r & (start | mfhi_req | mflo_req);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected HI/LO from an
// arithmetic reference model; a monitor reads HI/LO whenever busy falls.
module tb_muldiv_sequencer;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        chk_len;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        flush;
  logic        mfhi_req;
  logic        mflo_req;
  logic [31:0] read_data;
  logic        busy;
  logic        stall;

  logic        stim_mfhi, stim_mflo, mon_mfhi, mon_mflo;
  exp_t        exp_q[$];
  logic [31:0] model_hi, model_lo, prev_hi, prev_lo;
  int          n_cmp, n_fail;

  assign mfhi_req = stim_mfhi | mon_mfhi;
  assign mflo_req = stim_mflo | mon_mflo;

  muldiv_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs        (rs),
    .rt        (rt),
    .flush     (flush),
    .mfhi_req  (mfhi_req),
    .mflo_req  (mflo_req),
    .read_data (read_data),
    .busy      (busy),
    .stall     (stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: {HI, LO} straight from signed/unsigned integer arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 64'd0;
    case (o)
      2'b00: begin p = sa * sb; r = p; end
      2'b01: r = {32'd0, a} * {32'd0, b};
      2'b10: if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
             else r = {32'(sa % sb), 32'(sa / sb)};
      default: if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
               else r = {a % b, a / b};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic push_exp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    exp_t e;
    r = model(o, a, b);
    prev_hi = model_hi;
    prev_lo = model_lo;
    model_hi = r[63:32];
    model_lo = r[31:0];
    e.hi = model_hi;
    e.lo = model_lo;
    e.chk_len = 1'b1;
    exp_q.push_back(e);
  endtask

  // Replace the in-flight expectation after an abort (no length check)
  task automatic retarget_last(input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.chk_len = 1'b0;
    exp_q[exp_q.size() - 1] = e;
    model_hi = h;
    model_lo = l;
  endtask

  // Called at posedge+1 with busy low
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clock); #1;
    start = 1'b0;
    push_exp(o, a, b);
    chk("accept_busy", busy, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  // Monitor: on each busy fall read HI then LO and compare with the queue head
  initial begin
    logic prev_busy;
    int blen;
    exp_t e;
    logic [31:0] got_hi, got_lo;
    prev_busy = 1'b0;
    blen = 0;
    mon_mfhi = 1'b0;
    mon_mflo = 1'b0;
    forever begin
      @(negedge clock);
      if (busy) begin
        blen++;
      end else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: got busy fall, expected none");
        end else begin
          e = exp_q.pop_front();
          mon_mfhi = 1'b1;
          #1 got_hi = read_data;
          mon_mfhi = 1'b0;
          mon_mflo = 1'b1;
          #1 got_lo = read_data;
          mon_mflo = 1'b0;
          chk("result_hi", got_hi, e.hi);
          chk("result_lo", got_lo, e.lo);
          if (e.chk_len) chk("busy_cycles", blen, 33);
        end
        blen = 0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    int n;
    logic [1:0] ro;
    logic [31:0] ra, rb;
    n_cmp = 0; n_fail = 0;
    model_hi = 32'd0; model_lo = 32'd0; prev_hi = 32'd0; prev_lo = 32'd0;
    reset = 1'b1; start = 1'b0; op = 2'b00; rs = 32'd0; rt = 32'd0; flush = 1'b0;
    stim_mfhi = 1'b0; stim_mflo = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    chk("reset_busy", busy, 0);
    chk("reset_stall", stall, 0);
    chk("reset_noreq", read_data, 0);
    stim_mfhi = 1'b1;
    #1 chk("reset_hi", read_data, 0);
    stim_mfhi = 1'b0; stim_mflo = 1'b1;
    #1 chk("reset_lo", read_data, 0);
    stim_mflo = 1'b0;
    @(posedge clock); #1;

    // Directed arithmetic corners
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
    issue(2'b00, 32'hFFFF_FFFD, 32'd5);         wait_idle();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);         wait_idle();
    issue(2'b11, 32'd100, 32'd0);               wait_idle();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    issue(2'b10, 32'hFFFF_FFF9, 32'd0);         wait_idle();

    // mflo held from cycle 2 of DIVU 100/7
    issue(2'b11, 32'd100, 32'd7);
    @(posedge clock); #1;
    stim_mflo = 1'b1;
    n = 0;
    forever begin
      @(negedge clock); #3;
      if (!busy || n > 100) break;
      chk("stall_hold", stall, 1);
      n++;
    end
    chk("stall_release", stall, 0);
    chk("mflo_read", read_data, 32'h0000_000E);
    stim_mfhi = 1'b1;
    #1 chk("mfhi_read", read_data, 32'h0000_0002);
    stim_mfhi = 1'b0; stim_mflo = 1'b0;
    @(posedge clock); #1;

    // Back-to-back: start held through busy
    start = 1'b1; op = 2'b01; rs = 32'd1234; rt = 32'd5678;
    @(posedge clock); #1;
    push_exp(2'b01, 32'd1234, 32'd5678);
    chk("b2b_first_accept", busy, 1);
    op = 2'b10; rs = 32'hFFFF_0000; rt = 32'd77;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("b2b_stall_low", stall, 0);
    push_exp(2'b10, 32'hFFFF_0000, 32'd77);
    @(posedge clock); #1;
    start = 1'b0;
    chk("b2b_second_accept", busy, 1);
    wait_idle();

    // Flush at cycle 10 keeps HI=0x11 LO=0x22
    issue(2'b11, 32'h0000_0451, 32'h0000_0020); wait_idle();
    issue(2'b00, $urandom, $urandom);
    repeat (9) @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    retarget_last(32'h11, 32'h22);
    @(posedge clock); #1;

    // flush and start together in IDLE: nothing accepted
    start = 1'b1; flush = 1'b1; op = 2'b01; rs = 32'd9; rt = 32'd9;
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_idle", busy, 0);
    @(posedge clock); #1;

    // Asynchronous reset mid-RUN
    issue(2'b11, 32'h0000_0451, 32'h0000_0020); wait_idle();
    issue(2'b00, $urandom, $urandom);
    repeat (5) @(posedge clock);
    @(negedge clock); #2;
    reset = 1'b1;
    #1 chk("reset_async_busy", busy, 0);
    retarget_last(32'd0, 32'd0);
    @(negedge clock); #3;
    reset = 1'b0;
    @(posedge clock); #1;

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      issue(ro, ra, rb);
      wait_idle();
    end

    repeat (3) @(posedge clock);
    #1 chk("queue_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
